// File: rtl/switch_allocator_if.sv
// Handshake bundle between the input queues/route compute (master) and the switch allocator (slave).
// Carries the request matrix and downstream enables in, and the registered grants and crossbar selects out.
interface switch_allocator_if #(
  parameter int N = 5,
  parameter int M = 5
);
  localparam int SW = $clog2(N);

  logic [0:N-1][0:M-1] i_req;
  logic [0:M-1]        i_en;
  logic [0:N-1][0:M-1] o_grant;
  logic [0:M-1][SW-1:0] o_sel;
  logic [0:M-1]        o_sel_val;

  modport master (output i_req, i_en, input o_grant, o_sel, o_sel_val);
  modport slave  (input i_req, i_en, output o_grant, o_sel, o_sel_val);
endinterface

// File: rtl/switch_allocator.sv
// Round-robin switch allocator: one winner per output, one output per input; 1-cycle registered grant.
// Backpressure: an output whose i_en is low issues no grant and keeps its pointer.
module switch_allocator #(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  switch_allocator_if.slave sa
);
  localparam int SW = $clog2(N);
  localparam logic [SW:0]   N_W  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [0:N-1][0:M-1]  grant_q, grant_d;
  logic [0:M-1][SW-1:0] sel_q, sel_d;
  logic [0:M-1]         sel_val_q, sel_val_d;
  logic [0:M-1][SW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [0:N-1]  busy;
    logic          found;
    logic [SW:0]   sum;
    logic [SW-1:0] idx;

    grant_d   = '0;
    sel_d     = '0;
    sel_val_d = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;

    // An input popping this cycle must not be granted again while its stale request is still visible.
    for (int n = 0; n < N; n++) begin
      busy[n] = |grant_q[n];
    end

    for (int m = 0; m < M; m++) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr_q[m]} + (SW+1)'(k);
        idx = (sum >= N_W) ? SW'(sum - N_W) : SW'(sum);
        if (!found && sa.i_en[m] && sa.i_req[idx][m] && !busy[idx]) begin
          found           = 1'b1;
          grant_d[idx][m] = 1'b1;
          sel_d[m]        = idx;
          sel_val_d[m]    = 1'b1;
          busy[idx]       = 1'b1;
          ptr_d[m]        = (idx == LAST) ? '0 : idx + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q   <= '0;
      sel_q     <= '0;
      sel_val_q <= '0;
      ptr_q     <= '0;
    end else begin
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      sel_val_q <= sel_val_d;
      ptr_q     <= ptr_d;
    end
  end

  assign sa.o_grant   = grant_q;
  assign sa.o_sel     = sel_q;
  assign sa.o_sel_val = sel_val_q;
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: hand-computed grants/selects per step plus per-cycle invariants.
module tb_switch_allocator;
  localparam int N  = 5;
  localparam int M  = 5;
  localparam int SW = 3;

  logic         clk;
  logic         reset_n;
  logic [0:M-1] en_prev;
  int           tests = 0;
  int           fails = 0;
  int           t2_exp [6] = '{0, 1, 3, 0, 1, 3};

  switch_allocator_if #(.N(N), .M(M)) sa_if ();

  switch_allocator #(.N(N), .M(M)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sa      (sa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:N-1][0:M-1] gmat(input int n, input int m);
    logic [0:N-1][0:M-1] g = '0;
    g[n][m] = 1'b1;
    return g;
  endfunction

  function automatic logic [0:M-1] vbit(input int m);
    logic [0:M-1] v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:M-1][SW-1:0] smat(input int m, input int n);
    logic [0:M-1][SW-1:0] s = '0;
    s[m] = SW'(n);
    return s;
  endfunction

  task automatic check_inv();
    logic [0:M-1] col_or = '0;
    int bad_oh  = 0;
    int bad_sel = 0;
    for (int n = 0; n < N; n++) begin
      if ($countones(sa_if.o_grant[n]) > 1) bad_oh++;
      for (int m = 0; m < M; m++) begin
        if (sa_if.o_grant[n][m] === 1'b1) begin
          col_or[m] = 1'b1;
          if (sa_if.o_sel[m] !== SW'(n)) bad_sel++;
        end
      end
    end
    for (int m = 0; m < M; m++) begin
      int c = 0;
      for (int n = 0; n < N; n++) c += int'(sa_if.o_grant[n][m]);
      if (c > 1) bad_oh++;
    end
    check("inv_sel_val_eq_col_or", 32'(sa_if.o_sel_val), 32'(col_or));
    check("inv_onehot_rows_cols", bad_oh, 0);
    check("inv_grant_sel_match", bad_sel, 0);
    check("inv_no_grant_when_disabled", 32'(col_or & ~en_prev), 0);
  endtask

  task automatic tick();
    en_prev = sa_if.i_en;
    @(posedge clk);
    #1;
    check_inv();
  endtask

  initial begin
    reset_n     = 1'b0;
    sa_if.i_req = '0;
    sa_if.i_en  = '0;
    tick();
    // Requests presented during reset must not produce a grant.
    sa_if.i_req[1][1] = 1'b1;
    sa_if.i_en  = '1;
    tick();
    check("rst_grant", 32'(sa_if.o_grant), 0);
    check("rst_sel", 32'(sa_if.o_sel), 0);
    check("rst_sel_val", 32'(sa_if.o_sel_val), 0);
    check("rst_ptr", 32'(dut.ptr_q), 0);
    sa_if.i_req = '0;
    sa_if.i_en  = '0;
    reset_n     = 1'b1;

    // T1: single request
    sa_if.i_en[4]     = 1'b1;
    sa_if.i_req[2][4] = 1'b1;
    tick();
    check("t1_grant", 32'(sa_if.o_grant), 32'(gmat(2, 4)));
    check("t1_sel", 32'(sa_if.o_sel), 32'(smat(4, 2)));
    check("t1_sel_val", 32'(sa_if.o_sel_val), 32'(vbit(4)));
    check("t1_ptr4", 32'(dut.ptr_q[4]), 3);
    sa_if.i_req = '0;
    tick();
    check("t1_one_shot", 32'(sa_if.o_grant), 0);

    // T2: round-robin among inputs 0,1,3 on output 1
    sa_if.i_en        = '1;
    sa_if.i_req[0][1] = 1'b1;
    sa_if.i_req[1][1] = 1'b1;
    sa_if.i_req[3][1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t2_grant_%0d", i), 32'(sa_if.o_grant), 32'(gmat(t2_exp[i], 1)));
      check($sformatf("t2_sel_%0d", i), 32'(sa_if.o_sel[1]), 32'(t2_exp[i]));
    end
    sa_if.i_req = '0;
    tick();
    check("t2_idle", 32'(sa_if.o_grant), 0);

    // T3: backpressure holds off grant and pointer
    sa_if.i_en[2]     = 1'b0;
    sa_if.i_req[0][2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_blocked_%0d", i), 32'(sa_if.o_grant), 0);
    end
    check("t3_ptr2_held", 32'(dut.ptr_q[2]), 0);
    sa_if.i_en[2] = 1'b1;
    tick();
    check("t3_grant", 32'(sa_if.o_grant), 32'(gmat(0, 2)));
    check("t3_sel_val", 32'(sa_if.o_sel_val), 32'(vbit(2)));
    check("t3_ptr2", 32'(dut.ptr_q[2]), 1);
    sa_if.i_req = '0;
    tick();

    // Grant mask: a held request is not regranted in the pop cycle
    sa_if.i_req[2][0] = 1'b1;
    tick();
    check("mask_first", 32'(sa_if.o_grant), 32'(gmat(2, 0)));
    tick();
    check("mask_pop_cycle", 32'(sa_if.o_grant), 0);
    tick();
    check("mask_again", 32'(sa_if.o_grant), 32'(gmat(2, 0)));
    sa_if.i_req = '0;
    tick();
    check("mask_idle", 32'(sa_if.o_grant), 0);

    // T4: pointer wrap on output 3
    sa_if.i_req[3][3] = 1'b1;
    tick();
    check("t4_setup_grant", 32'(sa_if.o_grant), 32'(gmat(3, 3)));
    check("t4_setup_ptr3", 32'(dut.ptr_q[3]), 4);
    sa_if.i_req       = '0;
    sa_if.i_req[0][3] = 1'b1;
    sa_if.i_req[4][3] = 1'b1;
    tick();
    check("t4_grant_in4", 32'(sa_if.o_grant), 32'(gmat(4, 3)));
    check("t4_sel_in4", 32'(sa_if.o_sel[3]), 4);
    check("t4_ptr3_wrap", 32'(dut.ptr_q[3]), 0);
    tick();
    check("t4_grant_in0", 32'(sa_if.o_grant), 32'(gmat(0, 3)));
    check("t4_sel_in0", 32'(sa_if.o_sel[3]), 0);
    sa_if.i_req = '0;
    tick();

    // T5: one input requesting two outputs gets only the lower one
    sa_if.i_req[0][1] = 1'b1;
    sa_if.i_req[0][3] = 1'b1;
    tick();
    check("t5_grant", 32'(sa_if.o_grant), 32'(gmat(0, 1)));
    check("t5_sel_val", 32'(sa_if.o_sel_val), 32'(vbit(1)));
    check("t5_sel", 32'(sa_if.o_sel), 0);
    sa_if.i_req = '0;
    tick();

    // Independent outputs granted in the same cycle
    sa_if.i_req[1][0] = 1'b1;
    sa_if.i_req[3][2] = 1'b1;
    tick();
    check("par_grant", 32'(sa_if.o_grant), 32'(gmat(1, 0) | gmat(3, 2)));
    check("par_sel", 32'(sa_if.o_sel), 32'(smat(0, 1) | smat(2, 3)));
    check("par_sel_val", 32'(sa_if.o_sel_val), 32'(vbit(0) | vbit(2)));
    sa_if.i_req = '0;
    tick();

    // T6: reset in the middle of round-robin traffic (ptr[1] is 1 here)
    sa_if.i_req[0][1] = 1'b1;
    sa_if.i_req[1][1] = 1'b1;
    sa_if.i_req[3][1] = 1'b1;
    tick();
    check("t6_pre_a", 32'(sa_if.o_grant), 32'(gmat(1, 1)));
    tick();
    check("t6_pre_b", 32'(sa_if.o_grant), 32'(gmat(3, 1)));
    reset_n = 1'b0;
    tick();
    check("t6_rst_grant", 32'(sa_if.o_grant), 0);
    check("t6_rst_sel", 32'(sa_if.o_sel), 0);
    check("t6_rst_sel_val", 32'(sa_if.o_sel_val), 0);
    check("t6_rst_ptr", 32'(dut.ptr_q), 0);
    reset_n = 1'b1;
    tick();
    check("t6_post_grant", 32'(sa_if.o_grant), 32'(gmat(0, 1)));
    check("t6_post_sel", 32'(sa_if.o_sel[1]), 0);
    sa_if.i_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
